counter_7: RTL and testbench

Free-running modulo-7 counter that emits a one-clock terminal-count tick every seventh clock cycle. It is a level-3 timing primitive in the microwave controller. It serves as a divide-by-7 time base feeding higher-level timers and display sequencing. Counting is unconditional whenever reset is deasserted.

---
 rtl/counter_7_pkg.sv | 11 +
 rtl/counter_7.sv | 37 +++
 tb/tb_counter_7.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_7_pkg.sv
// +--------------------------------------------------------------------+
// | counter_7_pkg : timing-divider constants for the microwave control |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

package counter_7_pkg;
  localparam int COUNTER_7_MODULUS = 7;
endpackage

`default_nettype wire

// File: rtl/counter_7.sv
// +--------------------------------------------------------------------+
// | counter_7 : free-running modulo-MODULUS counter, 1-cycle tick      |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module counter_7
  import counter_7_pkg::*;
#(
  parameter int MODULUS = COUNTER_7_MODULUS,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic clk,
  input  logic clr,
  output logic value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count;

  // Compare with >= so counts that should never occur fall back to zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (count >= LAST) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign value = (count == LAST);

endmodule

`default_nettype wire

// File: tb/tb_counter_7.sv
// +--------------------------------------------------------------------+
// | tb_counter_7 : scoreboard bench for counter_7 (MODULUS 7 and 2)    |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_counter_7;

  logic clk;
  logic clr;
  logic value7;
  logic value2;

  int checks;
  int errors;

  int   m7;
  int   m2;
  bit   q7[$];
  bit   q2[$];

  counter_7 dut (
    .clk   (clk),
    .clr   (clr),
    .value (value7)
  );

  counter_7 #(.MODULUS(2)) dut2 (
    .clk   (clk),
    .clr   (clr),
    .value (value2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies clr for one rising edge, pushes the expected ticks, samples 1 ns later.
  task automatic drive(input logic c);
    clr = c;
    @(posedge clk);
    if (c) begin
      m7 = 0;
      m2 = 0;
    end else begin
      m7 = (m7 >= 6) ? 0 : m7 + 1;
      m2 = (m2 >= 1) ? 0 : m2 + 1;
    end
    q7.push_back(m7 == 6);
    q2.push_back(m2 == 1);
    #1;
  endtask

  task automatic test_reset();
    bit exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1);
      exp = q7.pop_front();
      checks++;
      if (value7 !== exp || value7 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d] value=%b required=0", i, value7);
      end
    end
    q2.delete();
  endtask

  task automatic test_free_run();
    bit exp;
    int ticks;
    ticks = 0;
    for (int n = 1; n <= 20; n++) begin
      drive(1'b0);
      exp = q7.pop_front();
      checks++;
      if (value7 !== exp) begin
        errors++;
        $display("FAIL free_run[edge %0d] value=%b required=%b", n, value7, exp);
      end
      if (value7 === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL free_run_ticks count=%0d required=3", ticks);
    end
    q2.delete();
  endtask

  task automatic test_wrap();
    bit exp;
    // Entering with the count at 6 after the 20-edge run.
    checks++;
    if (value7 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pre value=%b required=1", value7);
    end
    drive(1'b0);
    exp = q7.pop_front();
    checks++;
    if (value7 !== exp || value7 !== 1'b0) begin
      errors++;
      $display("FAIL wrap value=%b required=0", value7);
    end
    q2.delete();
  endtask

  task automatic test_reset_mid();
    bit exp;
    drive(1'b1);
    void'(q7.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      void'(q7.pop_front());
    end
    drive(1'b1);
    exp = q7.pop_front();
    checks++;
    if (value7 !== exp) begin
      errors++;
      $display("FAIL reset_mid value=%b required=%b", value7, exp);
    end
    for (int n = 1; n <= 6; n++) begin
      drive(1'b0);
      exp = q7.pop_front();
      checks++;
      if (value7 !== exp || value7 !== (n == 6)) begin
        errors++;
        $display("FAIL reset_mid_release[edge %0d] value=%b required=%b", n, value7, exp);
      end
    end
    q2.delete();
  endtask

  task automatic test_reset_terminal();
    bit exp;
    drive(1'b1);
    void'(q7.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b0);
      void'(q7.pop_front());
    end
    checks++;
    if (value7 !== 1'b1) begin
      errors++;
      $display("FAIL terminal_pre value=%b required=1", value7);
    end
    drive(1'b1);
    exp = q7.pop_front();
    checks++;
    if (value7 !== exp || value7 !== 1'b0) begin
      errors++;
      $display("FAIL terminal_reset value=%b required=0", value7);
    end
    for (int n = 1; n <= 7; n++) begin
      drive(1'b0);
      exp = q7.pop_front();
      checks++;
      if (value7 !== exp) begin
        errors++;
        $display("FAIL terminal_release[edge %0d] value=%b required=%b", n, value7, exp);
      end
    end
    q2.delete();
  endtask

  task automatic test_mod2();
    bit exp;
    q2.delete();
    drive(1'b1);
    exp = q2.pop_front();
    checks++;
    if (value2 !== exp || value2 !== 1'b0) begin
      errors++;
      $display("FAIL mod2_reset value=%b required=0", value2);
    end
    for (int n = 1; n <= 6; n++) begin
      drive(1'b0);
      exp = q2.pop_front();
      checks++;
      if (value2 !== exp || value2 !== n[0]) begin
        errors++;
        $display("FAIL mod2[edge %0d] value=%b required=%b", n, value2, exp);
      end
    end
    q7.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m7     = 0;
    m2     = 0;
    clr    = 1'b1;
    test_reset();
    test_free_run();
    test_wrap();
    test_reset_mid();
    test_reset_terminal();
    test_mod2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
